// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encodings, branch
// condition codes and flag bit positions.
package alu_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXEC   = 2'd1,
      S_SYNC   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   localparam logic [2:0] COND_AL = 3'd0;
   localparam logic [2:0] COND_EQ = 3'd1;
   localparam logic [2:0] COND_NE = 3'd2;
   localparam logic [2:0] COND_CS = 3'd3;
   localparam logic [2:0] COND_CC = 3'd4;
   localparam logic [2:0] COND_HI = 3'd5;
   localparam logic [2:0] COND_LS = 3'd6;
   localparam logic [2:0] COND_NV = 3'd7;

   localparam int FLG_C = 1;
   localparam int FLG_Z = 0;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational branch condition evaluator over a {C,Z} flag pair.
// Kept standalone so the branch unit can reuse it.
module alu_cond_eval
   import alu_seq_ctrl_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [1:0] flags,
   output logic       cond_true
);

   logic c_flag;
   logic z_flag;

   assign c_flag = flags[FLG_C];
   assign z_flag = flags[FLG_Z];

   // Decode the condition code against the selected flags
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_AL: cond_true = 1'b1;
         COND_EQ: cond_true = z_flag;
         COND_NE: cond_true = ~z_flag;
         COND_CS: cond_true = c_flag;
         COND_CC: cond_true = ~c_flag;
         COND_HI: cond_true = c_flag & ~z_flag;
         COND_LS: cond_true = ~c_flag | z_flag;
         COND_NV: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: accepts one op at a time, runs it for EXEC_CYC cycles,
// strobes flag capture, then flag commit and writeback.
// Optional macro ALU_SEQ_BYPASS_EN forwards the flags being committed in
// COMMIT to the condition evaluator instead of the committed flag register.
module alu_seq_ctrl
   import alu_seq_ctrl_pkg::*;
#(
   parameter int EXEC_CYC = 2,
   parameter int CNT_W    = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] op,
   input  logic       upd_flags,
   input  logic       hold,
   input  logic       flush,
   input  logic [1:0] flag_new,
   input  logic [1:0] flag_cur,
   input  logic [2:0] cond,
   output logic       ready,
   output logic       alu_en,
   output logic [3:0] alu_op,
   output logic       flag_sync,
   output logic       flag_we,
   output logic       wb_en,
   output logic       done,
   output logic       cond_true
);

   state_t     state;
   state_t     state_nxt;
   logic [CNT_W-1:0] cnt;
   logic       upd_flags_q;
   logic [1:0] snapshot;
   logic [1:0] flags_sel;
   logic       accept;

   assign accept = start & ready;

   // State register, execute counter, op latches and flag snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         alu_op      <= 4'd0;
         upd_flags_q <= 1'b0;
         snapshot    <= 2'b00;
      end else begin
         state <= state_nxt;
         if (accept) begin
            alu_op      <= op;
            upd_flags_q <= upd_flags;
            cnt         <= CNT_W'(EXEC_CYC - 1);
         end else if (state == S_EXEC && !hold && !flush && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (flag_sync) begin
            snapshot <= flag_new;
         end
      end
   end

   // Next-state and strobe decode; flush wins over hold, hold freezes everything
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      alu_en    = 1'b0;
      flag_sync = 1'b0;
      flag_we   = 1'b0;
      wb_en     = 1'b0;
      done      = 1'b0;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               ready = 1'b1;
               if (start) state_nxt = S_EXEC;
            end
            S_EXEC: begin
               alu_en = 1'b1;
               if (!hold && cnt == '0) state_nxt = S_SYNC;
            end
            S_SYNC: begin
               if (!hold) begin
                  flag_sync = upd_flags_q;
                  state_nxt = S_COMMIT;
               end
            end
            S_COMMIT: begin
               if (!hold) begin
                  flag_we   = upd_flags_q;
                  wb_en     = 1'b1;
                  done      = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_BYPASS_EN
   assign flags_sel = (state == S_COMMIT && upd_flags_q && !flush) ? snapshot : flag_cur;
`else
   logic unused_snapshot;
   assign unused_snapshot = ^snapshot;
   assign flags_sel = flag_cur;
`endif

   alu_cond_eval u_cond_eval (
      .cond      (cond),
      .flags     (flags_sel),
      .cond_true (cond_true)
   );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl (EXEC_CYC=2). Cycle-by-cycle vector
// tables for the sequencing behaviour plus hand-written reset, flush and
// flag-forwarding sequences, and a table sweep of every condition code.
module tb_alu_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] op;
   logic       upd_flags;
   logic       hold;
   logic       flush;
   logic [1:0] flag_new;
   logic [1:0] flag_cur;
   logic [2:0] cond;
   logic       ready;
   logic       alu_en;
   logic [3:0] alu_op;
   logic       flag_sync;
   logic       flag_we;
   logic       wb_en;
   logic       done;
   logic       cond_true;

   int checks;
   int failures;

   // One entry per clock cycle: inputs for that cycle and the expected
   // {ready, alu_en, flag_sync, flag_we, wb_en, done}
   typedef struct {
      logic       start;
      logic       upd;
      logic       hold;
      logic       flush;
      logic [5:0] exp;
   } seq_vec_t;

   // Expected cond_true for flags {C,Z} = 0..3 held in mask bit [flags]
   typedef struct {
      logic [2:0] cond;
      logic [3:0] mask;
   } cond_vec_t;

   seq_vec_t  seqTab[$];
   cond_vec_t condTab[8];

   alu_seq_ctrl #(.EXEC_CYC(2), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .upd_flags (upd_flags),
      .hold      (hold),
      .flush     (flush),
      .flag_new  (flag_new),
      .flag_cur  (flag_cur),
      .cond      (cond),
      .ready     (ready),
      .alu_en    (alu_en),
      .alu_op    (alu_op),
      .flag_sync (flag_sync),
      .flag_we   (flag_we),
      .wb_en     (wb_en),
      .done      (done),
      .cond_true (cond_true)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [5:0] outVec();
      return {ready, alu_en, flag_sync, flag_we, wb_en, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [3:0] o, input logic u,
                                input logic h, input logic f);
      start     = s;
      op        = o;
      upd_flags = u;
      hold      = h;
      flush     = f;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   initial begin
      // Sequence A: op with flag update, no stalls
      seqTab.push_back('{1, 1, 0, 0, 6'b100000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b001000});
      seqTab.push_back('{0, 0, 0, 0, 6'b000111});
      seqTab.push_back('{0, 0, 0, 0, 6'b100000});
      // Sequence B: op without flag update
      seqTab.push_back('{1, 0, 0, 0, 6'b100000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b000000});
      seqTab.push_back('{0, 0, 0, 0, 6'b000011});
      seqTab.push_back('{0, 0, 0, 0, 6'b100000});
      // Sequence C: hold for 3 cycles in SYNC delays done by 3
      seqTab.push_back('{1, 1, 0, 0, 6'b100000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 1, 0, 6'b000000});
      seqTab.push_back('{0, 0, 1, 0, 6'b000000});
      seqTab.push_back('{0, 0, 1, 0, 6'b000000});
      seqTab.push_back('{0, 0, 0, 0, 6'b001000});
      seqTab.push_back('{0, 0, 0, 0, 6'b000111});
      seqTab.push_back('{0, 0, 0, 0, 6'b100000});
      // Sequence D: hold on the last EXEC cycle keeps alu_en and stretches EXEC
      seqTab.push_back('{1, 1, 0, 0, 6'b100000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 1, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b001000});
      seqTab.push_back('{0, 0, 0, 0, 6'b000111});
      seqTab.push_back('{0, 0, 0, 0, 6'b100000});
      // Sequence E: flush during EXEC aborts; flush beats hold
      seqTab.push_back('{1, 1, 0, 0, 6'b100000});
      seqTab.push_back('{0, 0, 1, 1, 6'b000000});
      seqTab.push_back('{0, 0, 0, 0, 6'b100000});
      // Sequence F: flush during SYNC suppresses flag_sync
      seqTab.push_back('{1, 1, 0, 0, 6'b100000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 0, 6'b010000});
      seqTab.push_back('{0, 0, 0, 1, 6'b000000});
      seqTab.push_back('{0, 0, 0, 0, 6'b100000});

      condTab[0] = '{3'd0, 4'b1111};
      condTab[1] = '{3'd1, 4'b1010};
      condTab[2] = '{3'd2, 4'b0101};
      condTab[3] = '{3'd3, 4'b1100};
      condTab[4] = '{3'd4, 4'b0011};
      condTab[5] = '{3'd5, 4'b0100};
      condTab[6] = '{3'd6, 4'b1011};
      condTab[7] = '{3'd7, 4'b0000};

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      flag_new = 2'b00;
      flag_cur = 2'b00;
      cond     = 3'd0;
      applyStimulus(0, 4'h0, 0, 0, 0);
      tick();
      tick();
      checkOutput("reset_outputs", {2'b00, outVec()}, 8'b00100000);
      checkOutput("reset_alu_op", {4'h0, alu_op}, 8'h00);
      rst = 1'b0;
      tick();

      // Reset asserted mid-EXEC returns to IDLE with cleared latches
      applyStimulus(1, 4'h9, 1, 0, 0);
      tick();
      applyStimulus(0, 4'h0, 0, 0, 0);
      checkOutput("pre_reset_exec", {2'b00, outVec()}, 8'b00010000);
      checkOutput("pre_reset_op", {4'h0, alu_op}, 8'h09);
      rst = 1'b1;
      #1;
      checkOutput("async_reset_outputs", {2'b00, outVec()}, 8'b00100000);
      checkOutput("async_reset_alu_op", {4'h0, alu_op}, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("post_reset_outputs", {2'b00, outVec()}, 8'b00100000);

      // Table-driven sequencing vectors, one per clock cycle
      for (int i = 0; i < seqTab.size(); i++) begin
         applyStimulus(seqTab[i].start, 4'h3, seqTab[i].upd, seqTab[i].hold, seqTab[i].flush);
         checkOutput($sformatf("seq_%0d", i), {2'b00, outVec()}, {2'b00, seqTab[i].exp});
         if (seqTab[i].start)
            ;
         tick();
      end
      applyStimulus(0, 4'h0, 0, 0, 0);
      checkOutput("seq_alu_op_latched", {4'h0, alu_op}, 8'h03);

      // Flush in COMMIT suppresses commit; start under flush in IDLE is dropped
      applyStimulus(1, 4'h5, 1, 0, 0);
      tick();
      applyStimulus(0, 4'h0, 0, 0, 0);
      tick();
      tick();
      tick();
      applyStimulus(0, 4'h0, 0, 0, 1);
      checkOutput("flush_commit_strobes", {2'b00, outVec()}, 8'b00000000);
      tick();
      applyStimulus(1, 4'hA, 1, 0, 1);
      checkOutput("flush_idle_ready", {7'd0, ready}, 8'd0);
      tick();
      applyStimulus(0, 4'h0, 0, 0, 0);
      checkOutput("flush_start_dropped", {2'b00, outVec()}, 8'b00100000);
      checkOutput("flush_alu_op_kept", {4'h0, alu_op}, 8'h05);

      // Condition on flags being committed: forwarded only with the bypass build
      flag_cur = 2'b00;
      flag_new = 2'b01;
      cond     = 3'd1;
      applyStimulus(1, 4'h3, 1, 0, 0);
      tick();
      applyStimulus(0, 4'h0, 0, 0, 0);
      tick();
      tick();
      checkOutput("bypass_sync_strobe", {7'd0, flag_sync}, 8'd1);
      checkOutput("bypass_sync_cond", {7'd0, cond_true}, 8'd0);
      tick();
      checkOutput("bypass_commit_we", {7'd0, flag_we}, 8'd1);
`ifdef ALU_SEQ_BYPASS_EN
      checkOutput("bypass_commit_cond", {7'd0, cond_true}, 8'd1);
`else
      checkOutput("bypass_commit_cond", {7'd0, cond_true}, 8'd0);
`endif
      tick();
      checkOutput("bypass_idle_cond", {7'd0, cond_true}, 8'd0);
      flag_new = 2'b00;

      // Sweep every condition code against every flag value in IDLE
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 4; f++) begin
            cond     = condTab[c].cond;
            flag_cur = 2'(f);
            #1;
            checkOutput($sformatf("cond_%0d_flags_%0d", c, f), {7'd0, cond_true},
                        {7'd0, condTab[c].mask[f]});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
